// File: rtl/find_result_collector.sv
// -----------------------------------------------------------------------------
// find_result_collector
//
// Downstream stage of the parallel find array. A round-robin pointer visits
// each unit in turn; the first time a unit is seen with its done level high,
// its sequence and energy are captured. The collector tracks the minimum
// energy seen so far, the sequence that produced it and the unit index. Once
// every unit has reported, all_done is raised and the results are frozen
// until reset or clear. The outputs are meant to be register-mapped by the
// Wishbone interface for firmware readback.
//
// Optional feature macro: FIND_COLLECT_CYCLES_EN
//   defined   : o_cycles counts cycles from reset/clear until DONE is entered,
//               then freezes; it saturates at all ones.
//   undefined : o_cycles is tied to zero and no counter is built.
//
// Ports:
//   wb_clk_i     clock, all logic on the rising edge
//   wb_rst_ni    synchronous active-low reset
//   i_clear      synchronous soft clear, same effect as reset
//   i_seq        packed sequences, unit k at [k*SEQ_WIDTH +: SEQ_WIDTH]
//   i_e          packed energies,  unit k at [k*E_WIDTH +: E_WIDTH]
//   i_done       per-unit done level (seq/e stable while high)
//   o_best_seq   sequence of the current minimum
//   o_best_e     current minimum energy (all ones when nothing captured)
//   o_best_idx   unit index of the current minimum
//   o_best_valid at least one result captured
//   o_new_best   one-cycle pulse when the best registers change
//   o_count      number of units captured
//   o_all_done   every unit captured
//   o_cycles     cycle count (see macro above)
// -----------------------------------------------------------------------------
module find_result_collector #(
    parameter int SEQ_WIDTH      = 8,
    parameter int E_WIDTH        = 16,
    parameter int PARALLEL_UNITS = 2,
    parameter int IDX_WIDTH      = (PARALLEL_UNITS > 1) ? $clog2(PARALLEL_UNITS) : 1,
    parameter int CNT_WIDTH      = $clog2(PARALLEL_UNITS + 1)
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_ni,
    input  logic                                i_clear,
    input  logic [PARALLEL_UNITS*SEQ_WIDTH-1:0] i_seq,
    input  logic [PARALLEL_UNITS*E_WIDTH-1:0]   i_e,
    input  logic [PARALLEL_UNITS-1:0]           i_done,
    output logic [SEQ_WIDTH-1:0]                o_best_seq,
    output logic [E_WIDTH-1:0]                  o_best_e,
    output logic [IDX_WIDTH-1:0]                o_best_idx,
    output logic                                o_best_valid,
    output logic                                o_new_best,
    output logic [CNT_WIDTH-1:0]                o_count,
    output logic                                o_all_done,
    output logic [31:0]                         o_cycles
);

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [IDX_WIDTH-1:0]      ptr_r, ptr_s, ptr_inc_s;
    logic [PARALLEL_UNITS-1:0] captured_r, captured_s;
    logic [SEQ_WIDTH-1:0]      held_seq_r, held_seq_s;
    logic [E_WIDTH-1:0]        held_e_r, held_e_s;
    logic [IDX_WIDTH-1:0]      held_idx_r, held_idx_s;
    logic [SEQ_WIDTH-1:0]      best_seq_r, best_seq_s;
    logic [E_WIDTH-1:0]        best_e_r, best_e_s;
    logic [IDX_WIDTH-1:0]      best_idx_r, best_idx_s;
    logic                      best_valid_r, best_valid_s;
    logic                      new_best_r, new_best_s;
    logic [CNT_WIDTH-1:0]      count_r, count_s, count_inc_s;
    logic                      all_done_r, all_done_s;
    logic                      wipe_s;

    // Reset and clear are equivalent; both abort any capture in flight.
    assign wipe_s = !wb_rst_ni || i_clear;

    // Round-robin successor of the scan pointer and the incremented count.
    always_comb begin
        if (ptr_r == IDX_WIDTH'(PARALLEL_UNITS - 1)) begin
            ptr_inc_s = '0;
        end else begin
            ptr_inc_s = ptr_r + IDX_WIDTH'(1);
        end
        count_inc_s = count_r + CNT_WIDTH'(1);
    end

    // Next-state and datapath decisions for the scan/update/done sequencer.
    always_comb begin
        state_s      = state_r;
        ptr_s        = ptr_r;
        captured_s   = captured_r;
        held_seq_s   = held_seq_r;
        held_e_s     = held_e_r;
        held_idx_s   = held_idx_r;
        best_seq_s   = best_seq_r;
        best_e_s     = best_e_r;
        best_idx_s   = best_idx_r;
        best_valid_s = best_valid_r;
        new_best_s   = 1'b0;
        count_s      = count_r;
        all_done_s   = all_done_r;

        case (state_r)
            ST_SCAN: begin
                // The pointer parks on a unit while its result is processed,
                // so UPDATE can advance it from the same position.
                if (i_done[ptr_r] && !captured_r[ptr_r]) begin
                    held_seq_s = i_seq[ptr_r*SEQ_WIDTH +: SEQ_WIDTH];
                    held_e_s   = i_e[ptr_r*E_WIDTH +: E_WIDTH];
                    held_idx_s = ptr_r;
                    state_s    = ST_UPDATE;
                end else begin
                    ptr_s = ptr_inc_s;
                end
            end
            ST_UPDATE: begin
                captured_s[held_idx_r] = 1'b1;
                count_s                = count_inc_s;
                ptr_s                  = ptr_inc_s;
                // Strict compare: on a tie the earlier capture stays best.
                // The valid gate lets an all-ones first result still win.
                if (!best_valid_r || (held_e_r < best_e_r)) begin
                    best_seq_s   = held_seq_r;
                    best_e_s     = held_e_r;
                    best_idx_s   = held_idx_r;
                    best_valid_s = 1'b1;
                    new_best_s   = 1'b1;
                end else begin
                    new_best_s = 1'b0;
                end
                if (count_inc_s == CNT_WIDTH'(PARALLEL_UNITS)) begin
                    state_s    = ST_DONE;
                    all_done_s = 1'b1;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                all_done_s = 1'b1;
            end
            default: begin
                state_s = ST_SCAN;
            end
        endcase
    end

    // State and result registers with synchronous reset/clear.
    always_ff @(posedge wb_clk_i) begin
        if (wipe_s) begin
            state_r      <= ST_SCAN;
            ptr_r        <= '0;
            captured_r   <= '0;
            held_seq_r   <= '0;
            held_e_r     <= '0;
            held_idx_r   <= '0;
            best_seq_r   <= '0;
            best_e_r     <= '1;
            best_idx_r   <= '0;
            best_valid_r <= 1'b0;
            new_best_r   <= 1'b0;
            count_r      <= '0;
            all_done_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            captured_r   <= captured_s;
            held_seq_r   <= held_seq_s;
            held_e_r     <= held_e_s;
            held_idx_r   <= held_idx_s;
            best_seq_r   <= best_seq_s;
            best_e_r     <= best_e_s;
            best_idx_r   <= best_idx_s;
            best_valid_r <= best_valid_s;
            new_best_r   <= new_best_s;
            count_r      <= count_s;
            all_done_r   <= all_done_s;
        end
    end

`ifdef FIND_COLLECT_CYCLES_EN
    logic [31:0] cycles_r;

    // Run-time counter: stops once DONE is reached and never wraps.
    always_ff @(posedge wb_clk_i) begin
        if (wipe_s) begin
            cycles_r <= 32'd0;
        end else if ((state_r != ST_DONE) && (cycles_r != 32'hFFFF_FFFF)) begin
            cycles_r <= cycles_r + 32'd1;
        end else begin
            cycles_r <= cycles_r;
        end
    end

    assign o_cycles = cycles_r;
`else
    assign o_cycles = 32'd0;
`endif

    assign o_best_seq   = best_seq_r;
    assign o_best_e     = best_e_r;
    assign o_best_idx   = best_idx_r;
    assign o_best_valid = best_valid_r;
    assign o_new_best   = new_best_r;
    assign o_count      = count_r;
    assign o_all_done   = all_done_r;

endmodule

// File: tb/tb_find_result_collector.sv
// -----------------------------------------------------------------------------
// tb_find_result_collector
//
// Directed bench for find_result_collector with four units. Stimulus pushes
// the expected best-result updates into a queue; a monitor pops one entry
// for every o_new_best pulse and compares the best registers against it.
// The main process also checks reset values, counts and latencies directly.
// -----------------------------------------------------------------------------
module tb_find_result_collector;

    localparam int PU   = 4;
    localparam int SW   = 8;
    localparam int EW   = 16;
    localparam int IW   = 2;
    localparam int CW   = 3;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic [PU*SW-1:0] i_seq;
    logic [PU*EW-1:0] i_e;
    logic [PU-1:0]    i_done;
    logic [SW-1:0]    o_best_seq;
    logic [EW-1:0]    o_best_e;
    logic [IW-1:0]    o_best_idx;
    logic             o_best_valid;
    logic             o_new_best;
    logic [CW-1:0]    o_count;
    logic             o_all_done;
    logic [31:0]      o_cycles;

    typedef struct packed {
        logic [SW-1:0] seq;
        logic [EW-1:0] e;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   nb_cnt = 0;

    find_result_collector #(
        .SEQ_WIDTH      (SW),
        .E_WIDTH        (EW),
        .PARALLEL_UNITS (PU)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .i_clear      (clear),
        .i_seq        (i_seq),
        .i_e          (i_e),
        .i_done       (i_done),
        .o_best_seq   (o_best_seq),
        .o_best_e     (o_best_e),
        .o_best_idx   (o_best_idx),
        .o_best_valid (o_best_valid),
        .o_new_best   (o_new_best),
        .o_count      (o_count),
        .o_all_done   (o_all_done),
        .o_cycles     (o_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_unit(input int k, input logic [SW-1:0] s, input logic [EW-1:0] e);
        i_seq[k*SW +: SW] = s;
        i_e[k*EW +: EW]   = e;
    endtask

    task automatic push_exp(input logic [SW-1:0] s, input logic [EW-1:0] e, input logic [IW-1:0] idx);
        exp_t x;
        x.seq = s;
        x.e   = e;
        x.idx = idx;
        exp_q.push_back(x);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'(o_best_valid), 32'd0);
        check({tag, "_e"},     32'(o_best_e),     32'h0000_FFFF);
        check({tag, "_seq"},   32'(o_best_seq),   32'd0);
        check({tag, "_idx"},   32'(o_best_idx),   32'd0);
        check({tag, "_count"}, 32'(o_count),      32'd0);
        check({tag, "_alldn"}, 32'(o_all_done),   32'd0);
        check({tag, "_newb"},  32'(o_new_best),   32'd0);
        check({tag, "_cyc"},   o_cycles,          32'd0);
    endtask

    // Wait (bounded) until o_count reaches target, then check it.
    task automatic wait_count(input string name, input int target, input int bound);
        for (int c = 0; c < bound; c++) begin
            @(posedge clk);
            #1;
            if (int'(o_count) == target) break;
        end
        check(name, 32'(o_count), 32'(target));
    endtask

    // Scoreboard monitor: every new_best pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (o_new_best) begin
            nb_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_new_best_queue", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("sb_seq",   32'(o_best_seq),   32'(x.seq));
                check("sb_e",     32'(o_best_e),     32'(x.e));
                check("sb_idx",   32'(o_best_idx),   32'(x.idx));
                check("sb_valid", 32'(o_best_valid), 32'd1);
            end
        end
    end

    initial begin
        int n;
        logic [31:0] cyc_frozen;
        rst_n  = 1'b0;
        clear  = 1'b0;
        i_seq  = '0;
        i_e    = '0;
        i_done = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;

        // Idle: nothing done, nothing may change.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("idle_valid", 32'(o_best_valid), 32'd0);
            check("idle_e",     32'(o_best_e),     32'h0000_FFFF);
            check("idle_count", 32'(o_count),      32'd0);
            check("idle_alldn", 32'(o_all_done),   32'd0);
        end
        check("idle_nb_pulses", 32'(nb_cnt), 32'd0);

        // First capture: unit 2.
        set_unit(2, 8'hA5, 16'h0040);
        i_done[2] = 1'b1;
        push_exp(8'hA5, 16'h0040, 2'd2);
        wait_count("u2_count", 1, 5);
        check("u2_e",     32'(o_best_e),     32'h0000_0040);
        check("u2_seq",   32'(o_best_seq),   32'h0000_00A5);
        check("u2_idx",   32'(o_best_idx),   32'd2);
        check("u2_valid", 32'(o_best_valid), 32'd1);
        check("u2_alldn", 32'(o_all_done),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("u2_nb_pulses", 32'(nb_cnt), 32'd1);

        // Unit 0 beats it, unit 1 ties (keeps unit 0), unit 3 is worse.
        set_unit(0, 8'h11, 16'h0030);
        i_done[0] = 1'b1;
        push_exp(8'h11, 16'h0030, 2'd0);
        wait_count("u0_count", 2, 8);
        set_unit(1, 8'h22, 16'h0030);
        i_done[1] = 1'b1;
        wait_count("u1_count", 3, 8);
        set_unit(3, 8'h33, 16'h0050);
        i_done[3] = 1'b1;
        wait_count("u3_count", 4, 8);
        check("p3_alldn", 32'(o_all_done), 32'd1);
        check("p3_e",     32'(o_best_e),   32'h0000_0030);
        check("p3_idx",   32'(o_best_idx), 32'd0);
        check("p3_seq",   32'(o_best_seq), 32'h0000_0011);
        repeat (2) @(posedge clk);
        #1;
        check("p3_nb_pulses", 32'(nb_cnt), 32'd2);
        check("p3_queue_empty", 32'(exp_q.size()), 32'd0);

        // DONE holds regardless of input activity.
        cyc_frozen = o_cycles;
        i_done = 4'b0000;
        set_unit(1, 8'hEE, 16'h0001);
        repeat (3) @(posedge clk);
        i_done = 4'b1111;
        repeat (50) @(posedge clk);
        #1;
        check("hold_e",     32'(o_best_e),   32'h0000_0030);
        check("hold_idx",   32'(o_best_idx), 32'd0);
        check("hold_count", 32'(o_count),    32'd4);
        check("hold_alldn", 32'(o_all_done), 32'd1);
`ifdef FIND_COLLECT_CYCLES_EN
        check("cyc_nonzero", 32'(o_cycles != 32'd0), 32'd1);
        check("cyc_frozen", o_cycles, cyc_frozen);
`else
        check("cyc_zero", o_cycles, 32'd0);
`endif

        // Clear, then all four done in the same cycle: capture in ptr order.
        set_unit(0, 8'h01, 16'h0010);
        set_unit(1, 8'h02, 16'h0008);
        set_unit(2, 8'h03, 16'h0008);
        set_unit(3, 8'h04, 16'h0020);
        i_done = 4'b1111;
        clear  = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("clear1");
        clear = 1'b0;
        push_exp(8'h01, 16'h0010, 2'd0);
        push_exp(8'h02, 16'h0008, 2'd1);
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            n = c;
            if (o_all_done) break;
        end
        check("all4_latency", 32'(n), 32'd8);
        check("all4_alldn", 32'(o_all_done), 32'd1);
        check("all4_e",     32'(o_best_e),   32'h0000_0008);
        check("all4_idx",   32'(o_best_idx), 32'd1);
        check("all4_seq",   32'(o_best_seq), 32'h0000_0002);
        check("all4_count", 32'(o_count),    32'd4);
        repeat (2) @(posedge clk);
        #1;
        check("all4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Clear landing on an UPDATE cycle, then recapture with done still high.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(posedge clk);          // SCAN captures unit 0 -> UPDATE
        #1;
        clear = 1'b1;
        @(posedge clk);          // clear wins over the pending update
        #1;
        check_cleared("clear_upd");
        clear = 1'b0;
        push_exp(8'h01, 16'h0010, 2'd0);
        push_exp(8'h02, 16'h0008, 2'd1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (o_all_done) break;
        end
        check("rerun_alldn", 32'(o_all_done), 32'd1);
        check("rerun_count", 32'(o_count),    32'd4);
        check("rerun_e",     32'(o_best_e),   32'h0000_0008);
        check("rerun_idx",   32'(o_best_idx), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rerun_queue_empty", 32'(exp_q.size()), 32'd0);
        check("total_nb_pulses", 32'(nb_cnt), 32'd6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/find_result_collector.md
Name: find_result_collector

Overview:
- Downstream stage of the parallel find array; consumes each unit's packed seq/e/done outputs.
- Round-robin scanner captures each unit's result once and tracks the global minimum energy, its sequence and its unit index.
- Raises an all-done flag once every unit has reported.
- Outputs are register-mapped by the Wishbone interface for firmware readback.

Parameters:
- SEQ_WIDTH, 8, sequence width per unit.
- E_WIDTH, 16, energy width per unit (unsigned).
- PARALLEL_UNITS, 2, number of find units; must be >=1.
- IDX_WIDTH, (PARALLEL_UNITS>1 ? $clog2(PARALLEL_UNITS) : 1), unit index width.
- CNT_WIDTH, $clog2(PARALLEL_UNITS+1), completed-unit counter width.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_ni  in  1  synchronous active-low reset.
- i_clear  in  1  synchronous soft clear; same effect as reset.
- i_seq  in  PARALLEL_UNITS*SEQ_WIDTH  packed sequences; unit k at [k*SEQ_WIDTH +: SEQ_WIDTH].
- i_e  in  PARALLEL_UNITS*E_WIDTH  packed energies; unit k at [k*E_WIDTH +: E_WIDTH].
- i_done  in  PARALLEL_UNITS  per-unit done level; seq/e are stable while done is high.
- o_best_seq  out  SEQ_WIDTH  sequence of the current minimum.
- o_best_e  out  E_WIDTH  current minimum energy.
- o_best_idx  out  IDX_WIDTH  unit index of the current minimum.
- o_best_valid  out  1  at least one result has been captured.
- o_new_best  out  1  one-cycle pulse when best registers change.
- o_count  out  CNT_WIDTH  number of units captured.
- o_all_done  out  1  all units captured.
- o_cycles  out  32  cycle count (see Optional Feature).

Behaviour:
- Reset (wb_rst_ni=0) or i_clear=1 at an edge:
  - state=SCAN, ptr=0, captured mask=0.
  - o_best_seq=0, o_best_e=all ones, o_best_idx=0.
  - o_best_valid=0, o_new_best=0, o_count=0, o_all_done=0, o_cycles=0.
  - Reset has priority over clear; either aborts any in-flight capture.
- FSM:
  - SCAN: if i_done[ptr] && !captured[ptr], latch i_seq/i_e slice and ptr into holding registers and go to UPDATE. Otherwise ptr <= (ptr==PARALLEL_UNITS-1) ? 0 : ptr+1.
  - UPDATE:
    - set captured[ptr]; o_count+1.
    - If !o_best_valid || held_e < o_best_e (strict), load held seq/e/idx into best outputs, set o_best_valid, pulse o_new_best.
    - ptr wraps to next unit.
    - Next state is DONE if the new count equals PARALLEL_UNITS, else SCAN.
  - DONE: o_all_done=1; all outputs held until reset/clear. i_done changes are ignored.
- Latency:
  - done seen in SCAN at cycle t; outputs updated at the edge ending t+1; visible in cycle t+2.
  - Worst-case detection delay from done rising to SCAN visiting that unit: PARALLEL_UNITS-1 cycles.
- Ties: equal energy never replaces the existing best, so the first-captured result wins.
- A first capture with e = all ones still becomes best (o_best_valid gates the compare).
- A unit is captured exactly once per reset/clear epoch, even if i_done toggles.
- Done deasserting before it is scanned means that unit is not captured until it reasserts.
- PARALLEL_UNITS=1: ptr stays 0; DONE is reached after one UPDATE.
- o_new_best is low in every cycle except the one following an updating UPDATE edge.

Optional Feature:
- Macro: FIND_COLLECT_CYCLES_EN.
- Defined:
  - o_cycles increments every cycle from reset/clear while state != DONE.
  - It freezes on entering DONE and saturates at 32'hFFFF_FFFF.
- Undefined: o_cycles is tied to 0 and no counter logic is built.

Test Plan:
- PU=4, SEQ=8, E=16. Reset, no done -> for 20 cycles: o_best_valid=0, o_best_e=16'hFFFF, o_count=0, o_all_done=0, o_new_best never pulses.
- Set done[2], e2=16'h0040, seq2=8'hA5 -> o_best_e=0040, seq=A5, idx=2, valid=1, count=1, single o_new_best pulse within 2+3 cycles.
- Then done[0] with e=0x0030, done[1] with e=0x0030, done[3] with e=0x0050 -> final best e=0030, idx=0 (tie keeps first captured), count=4, o_all_done=1; exactly 2 total new_best pulses.
- Set all four done in the same cycle with e={0x10,0x08,0x08,0x20} -> captures in ptr order, best idx=1, e=0x08; all_done after 8 UPDATE/SCAN cycles max.
- Assert i_clear in UPDATE mid-run -> next cycle all outputs at reset values; re-running with done still high recaptures all units.
- With FIND_COLLECT_CYCLES_EN: all units done at cycle 5 after reset -> o_cycles frozen at the DONE-entry count and constant for 50 further cycles. Without the macro -> o_cycles=0 throughout.
